// File: rtl/uart_cmd_sync_ctrl.sv
// Decodes LF-terminated ASCII commands from uart_rx and gates N_CH PPS-sync enables with edge counts.
// Latency: LF accepted at t -> cmd_ok/cmd_err pulse, enable and edge-select update at t+1; PPS edge -> enable clear in 4 cycles.
// Backpressure: none; every i_rx_den strobe is consumed in the cycle it arrives.
module uart_cmd_sync_ctrl #(
  parameter int N_CH     = 2,
  parameter int ARG_W    = 16,
  parameter int MAX_LEN  = 16,
  parameter int EDGE_RST = 0
) (
  input  logic            i_clk,
  input  logic            i_res,
  input  logic [7:0]      i_rx_data,
  input  logic            i_rx_den,
  input  logic [N_CH-1:0] i_pps,
  output logic [N_CH-1:0] o_pps_sync_en,
  output logic            o_edge_sel,
  output logic            o_cmd_ok,
  output logic            o_cmd_err
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int EXT_W = ARG_W + 4;

  localparam logic [7:0] C_LF = 8'h0A;
  localparam logic [7:0] C_CR = 8'h0D;
  localparam logic [7:0] C_SP = 8'h20;
  localparam logic [7:0] C_0  = 8'h30;
  localparam logic [7:0] C_1  = 8'h31;
  localparam logic [7:0] C_9  = 8'h39;
  localparam logic [7:0] C_C  = 8'h63;
  localparam logic [7:0] C_E  = 8'h65;
  localparam logic [7:0] C_S  = 8'h73;
  localparam logic [7:0] C_X  = 8'h78;

  typedef enum logic [2:0] {
    S_CMD0, S_CMD1, S_CH, S_SP, S_ARG, S_EDGE, S_END, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        ch_q, ch_d;
  logic [ARG_W-1:0]  acc_q, acc_d;
  logic              have_dig_q, have_dig_d;
  logic              is_sx_q, is_sx_d;
  logic              edge_val_q, edge_val_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [N_CH-1:0]   en_q, en_d;
  logic [ARG_W-1:0]  rem_q [N_CH];
  logic [ARG_W-1:0]  rem_d [N_CH];
  logic [2:0]        sr_q [N_CH];
  logic [2:0]        sr_d [N_CH];
  logic [N_CH-1:0]   edge_q, edge_d;
  logic              edge_sel_q, edge_sel_d;
  logic              ok_q, ok_d;
  logic              err_q, err_d;

  // Command execution strobes produced by the parser on an accepted LF
  logic              arm_vld;
  logic [3:0]        arm_ch;
  logic [ARG_W-1:0]  arm_n;
  logic              sx_vld;
  logic              es_vld;
  logic              es_val;

  logic              is_digit;
  logic [3:0]        dig;
  logic [EXT_W-1:0]  acc_ext;

  assign is_digit = (i_rx_data >= C_0) && (i_rx_data <= C_9);
  assign dig      = i_rx_data[3:0];
  assign acc_ext  = EXT_W'(acc_q) * EXT_W'(10) + EXT_W'(dig);

  // Line parser: advances one step per received byte, CR is invisible, LF executes or rejects
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    acc_d      = acc_q;
    have_dig_d = have_dig_q;
    is_sx_d    = is_sx_q;
    edge_val_d = edge_val_q;
    len_d      = len_q;
    err_d      = 1'b0;
    arm_vld    = 1'b0;
    arm_ch     = 4'd0;
    arm_n      = ARG_W'(1);
    sx_vld     = 1'b0;
    es_vld     = 1'b0;
    es_val     = edge_val_q;
    if (i_rx_den && (i_rx_data != C_CR)) begin
      if (i_rx_data == C_LF) begin
        state_d = S_CMD0;
        len_d   = '0;
        case (state_q)
          S_CMD0: ;  // empty line is silently dropped
          S_CH: arm_vld = 1'b1;
          S_SP: begin
            arm_vld = 1'b1;
            arm_ch  = ch_q;
          end
          S_ARG: begin
            if (have_dig_q) begin
              arm_vld = 1'b1;
              arm_ch  = ch_q;
              arm_n   = acc_q;
            end else begin
              err_d = 1'b1;
            end
          end
          S_END: begin
            sx_vld = is_sx_q;
            es_vld = !is_sx_q;
          end
          default: err_d = 1'b1;
        endcase
      end else if (len_q == LEN_W'(MAX_LEN)) begin
        // one byte past the limit poisons the rest of the line
        state_d = S_ERR;
      end else begin
        len_d = len_q + LEN_W'(1);
        case (state_q)
          S_CMD0: state_d = (i_rx_data == C_S) ? S_CMD1 : S_ERR;
          S_CMD1: begin
            if (i_rx_data == C_C) begin
              state_d = S_CH;
            end else if (i_rx_data == C_X) begin
              state_d = S_END;
              is_sx_d = 1'b1;
            end else if (i_rx_data == C_E) begin
              state_d = S_EDGE;
              is_sx_d = 1'b0;
            end else begin
              state_d = S_ERR;
            end
          end
          S_CH: begin
            if (is_digit && (int'(dig) < N_CH)) begin
              ch_d    = dig;
              state_d = S_SP;
            end else begin
              state_d = S_ERR;
            end
          end
          S_SP: begin
            if (i_rx_data == C_SP) begin
              acc_d      = '0;
              have_dig_d = 1'b0;
              state_d    = S_ARG;
            end else begin
              state_d = S_ERR;
            end
          end
          S_ARG: begin
            if (is_digit && (acc_ext <= EXT_W'({ARG_W{1'b1}}))) begin
              acc_d      = acc_ext[ARG_W-1:0];
              have_dig_d = 1'b1;
            end else begin
              state_d = S_ERR;
            end
          end
          S_EDGE: begin
            if ((i_rx_data == C_0) || (i_rx_data == C_1)) begin
              edge_val_d = i_rx_data[0];
              state_d    = S_END;
            end else begin
              state_d = S_ERR;
            end
          end
          default: state_d = S_ERR;
        endcase
      end
    end
    ok_d = arm_vld || sx_vld || es_vld;
  end

  // Per-channel PPS synchroniser, edge detector and enable/remaining-count update
  always_comb begin
    edge_sel_d = es_vld ? es_val : edge_sel_q;
    for (int k = 0; k < N_CH; k++) begin
      sr_d[k]   = {sr_q[k][1:0], i_pps[k]};
      edge_d[k] = edge_sel_q ? (sr_q[k][2:1] == 2'b01) : (sr_q[k][2:1] == 2'b10);
      en_d[k]   = en_q[k];
      rem_d[k]  = rem_q[k];
      if (arm_vld && (int'(arm_ch) == k)) begin
        en_d[k]  = 1'b1;
        rem_d[k] = arm_n;
      end else if (sx_vld) begin
        en_d[k]  = 1'b0;
        rem_d[k] = '0;
      end else if (edge_q[k] && en_q[k]) begin
        if (rem_q[k] == ARG_W'(1)) begin
          en_d[k]  = 1'b0;
          rem_d[k] = '0;
        end else if (rem_q[k] != '0) begin
          rem_d[k] = rem_q[k] - ARG_W'(1);
        end
      end
    end
  end

  // State register for parser, channels and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      state_q    <= S_CMD0;
      ch_q       <= '0;
      acc_q      <= '0;
      have_dig_q <= 1'b0;
      is_sx_q    <= 1'b0;
      edge_val_q <= 1'b0;
      len_q      <= '0;
      en_q       <= '0;
      rem_q      <= '{default: '0};
      sr_q       <= '{default: '0};
      edge_q     <= '0;
      edge_sel_q <= (EDGE_RST != 0);
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      acc_q      <= acc_d;
      have_dig_q <= have_dig_d;
      is_sx_q    <= is_sx_d;
      edge_val_q <= edge_val_d;
      len_q      <= len_d;
      en_q       <= en_d;
      rem_q      <= rem_d;
      sr_q       <= sr_d;
      edge_q     <= edge_d;
      edge_sel_q <= edge_sel_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
    end
  end

  assign o_pps_sync_en = en_q;
  assign o_edge_sel    = edge_sel_q;
  assign o_cmd_ok      = ok_q;
  assign o_cmd_err     = err_q;

endmodule

// File: doc/uart_cmd_sync_ctrl.md
Name: uart_cmd_sync_ctrl

Overview:
Parametrised successor of the single-command UART PPS-sync gate. Consumes the byte stream from uart_rx (data + data-enable) and decodes LF-terminated ASCII commands. Controls N_CH independent PPS-sync enables, each with a programmable PPS-edge count. Sits between uart_rx and the per-channel PPS phase counters.

Parameters:
N_CH, 2, number of PPS channels / sync-enable outputs (1..10; channel is one ASCII digit)
ARG_W, 16, width of decimal count argument and per-channel remaining counter
MAX_LEN, 16, max bytes per line excluding CR/LF; longer lines are errors
EDGE_RST, 0, reset edge select (0 = PPS negedge, 1 = PPS posedge)

Ports:
i_clk  in  1  system clock
i_res  in  1  synchronous reset, active-high
i_rx_data  in  8  received byte from uart_rx
i_rx_den  in  1  one-cycle strobe, i_rx_data valid
i_pps  in  N_CH  asynchronous PPS inputs, one per channel
o_pps_sync_en  out  N_CH  per-channel sync enable
o_edge_sel  out  1  current edge select (0 neg, 1 pos)
o_cmd_ok  out  1  one-cycle pulse, command executed
o_cmd_err  out  1  one-cycle pulse, line rejected

Behaviour:
- Reset (synchronous, i_res=1 at posedge): o_pps_sync_en=0, o_edge_sel=EDGE_RST, o_cmd_ok=0, o_cmd_err=0, parser to S_CMD0, all counters 0, sync shift registers 0.
- Grammar (CR 0x0D ignored everywhere, LF 0x0A terminates):
  "sc" -> arm ch0, count 1 (legacy-compatible)
  "sc<d>" -> arm ch d, count 1
  "sc<d> <n>" -> arm ch d, count n (decimal, single space 0x20); n=0 = continuous
  "sx" -> disarm all channels
  "se0" / "se1" -> set o_edge_sel
- Parser FSM, advances only on i_rx_den:
  S_CMD0: 's' -> S_CMD1; else S_ERR
  S_CMD1: 'c' -> S_CH; 'x' -> S_END; 'e' -> S_EDGE; else S_ERR
  S_CH: digit -> S_SP (latch ch); LF -> execute arm ch0 n=1
  S_SP: ' ' -> S_ARG (acc=0); LF -> execute arm ch n=1
  S_ARG: digit -> acc=acc*10+d; LF -> execute arm ch n=acc (no digits received = error)
  S_EDGE: '0'/'1' -> S_END (latch); else S_ERR
  S_END: LF -> execute
  S_ERR: discard until LF, then o_cmd_err
  Any unexpected byte -> S_ERR. After any LF -> S_CMD0. Bare LF in S_CMD0 (empty line): ignored, no pulse.
- Error conditions (no state change, o_cmd_err pulse): grammar violation, ch >= N_CH, acc overflow past 2^ARG_W-1 (checked per digit), line length > MAX_LEN (non-CR bytes before LF).
- Latency: LF accepted at cycle t -> o_cmd_ok/o_cmd_err high at t+1 only; sync_en/edge_sel take new value at t+1.
- PPS path per channel: 3-bit shift register {sr[1:0], i_pps[k]}; negedge = sr[2:1]==2'b10, posedge = 2'b01; selected by o_edge_sel.
- Per channel, priority: arm > sx > edge. Arm: en=1, rem=n. sx: en=0, rem=0. Selected edge while en=1: if rem==1 -> en=0, rem=0; if rem==0 (continuous) -> hold; else rem-=1. Edges with en=0 ignored.
- Re-arm of an armed channel reloads rem; arm coincident with an edge on the same channel ignores that edge.
- Edge-select change applies from the next cycle; no spurious edge generated.
- Reset mid-line discards the partial line; no pulse.

Test Plan:
- Reset, then "sc\n" -> o_pps_sync_en=2'b01 and o_cmd_ok pulse one cycle after LF; one i_pps[0] falling edge -> en[0]=0 four cycles after the edge (2 sync + detect + register).
- "sc1 3\r\n", then 3 negedges on i_pps[1] -> en[1] stays 1 after edges 1 and 2, clears after edge 3; en[0] untouched throughout.
- "se1\n", "sc0 0\n", 5 PPS pulses, "sx\n" -> o_edge_sel=1; en[0] held through all pulses; cleared one cycle after sx LF.
- "sc5\n" (N_CH=2), "sc0 70000\n" (ARG_W=16), "sq\n", 20-byte line -> o_cmd_err pulse each, o_pps_sync_en unchanged, no o_cmd_ok.
- "sc\n" LF den in the same cycle as a detected negedge on an already-armed ch0 (rem=1) -> en[0]=1, rem=1 afterwards (arm wins).
- i_res asserted after "sc1 " mid-line, then "2\n" -> o_cmd_err (line starts with '2'), all outputs at reset values.
